uart_receiver: RTL

Serial-to-parallel UART receiver for the ULX3S UART loop: 8N1 framing, LSB first. Takes the asynchronous `rx` line, recovers one byte per frame by mid-bit sampling, and presents it as `data` with a one-cycle `data_ready` strobe. Framing errors are flagged. An optional sequence checker verifies that consecutive bytes increment by one, matching the incrementing test pattern our sender drives into the UART transmitter. This lets the loopback bench and the board self-check.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_rx_sync.sv | 14 +
 rtl/uart_receiver.sv | 100 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and framing constants
package uart_pkg;
  typedef enum logic [1:0] {sIDLE, sSTART, sDATA, sSTOP} state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 8;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer with configurable reset value
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] ff_q, ff_d;
  always_comb ff_d = {ff_q[0], d};
  always_ff @(posedge clk) ff_q <= reset ? {2{RESET_VAL}} : ff_d;
  assign q = ff_q[1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with mid-bit sampling, framing and sequence checks
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit SEQ_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_ready,
  output logic       framing_error,
  output logic       seq_error,
  output logic       busy
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [7:0] START_LAST = 8'(HALF - 1);
  localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IDX_LAST = 3'(UART_DATA_BITS - 1);
  logic rx_s;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, shift_q, shift_d, data_q, data_d, ref_q, ref_d;
  logic [2:0] idx_q, idx_d;
  logic dr_q, dr_d, fe_q, fe_d, se_q, se_d, ref_vld_q, ref_vld_d, busy_q, busy_d;
  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d(rx), .q(rx_s));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 8'd1;
    idx_d = idx_q;
    shift_d = shift_q;
    data_d = data_q;
    ref_d = ref_q;
    ref_vld_d = ref_vld_q;
    dr_d = 1'b0;
    fe_d = 1'b0;
    se_d = 1'b0;
    case (state_q)
      sIDLE: begin
        cnt_d = '0;
        state_d = rx_s ? sIDLE : sSTART;
      end
      sSTART: if (cnt_q == START_LAST) begin
        state_d = rx_s ? sIDLE : sDATA;
        cnt_d = '0;
        idx_d = '0;
      end
      sDATA: if (cnt_q == BIT_LAST) begin
        cnt_d = '0;
        shift_d[idx_q] = rx_s;
        idx_d = idx_q + 3'd1;
        state_d = (idx_q == IDX_LAST) ? sSTOP : sDATA;
      end
      sSTOP: if (cnt_q == BIT_LAST) begin
        state_d = sIDLE;
        cnt_d = '0;
        dr_d = rx_s;
        fe_d = !rx_s;
        data_d = rx_s ? shift_q : data_q;
        se_d = rx_s && SEQ_CHECK && ref_vld_q && (shift_q != ref_q + 8'd1);
        ref_d = rx_s ? shift_q : ref_q;
        ref_vld_d = ref_vld_q || rx_s;
      end
      default: state_d = sIDLE;
    endcase
    busy_d = state_d != sIDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= sIDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      ref_q <= '0;
      ref_vld_q <= 1'b0;
      dr_q <= 1'b0;
      fe_q <= 1'b0;
      se_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      data_q <= data_d;
      ref_q <= ref_d;
      ref_vld_q <= ref_vld_d;
      dr_q <= dr_d;
      fe_q <= fe_d;
      se_q <= se_d;
      busy_q <= busy_d;
    end
  end
  assign data = data_q;
  assign data_ready = dr_q;
  assign framing_error = fe_q;
  assign seq_error = se_q;
  assign busy = busy_q;
endmodule
